// File: rtl/mem_load_unit.sv
// ---------------------------------------------------------------------------
// mem_load_unit
//   Multi-cycle RISC-V load controller between the datapath and data memory.
//   Latches a load request, issues a doubleword-aligned read, waits for the
//   memory response (bounded by TIMEOUT cycles), extracts and sign/zero-
//   extends the addressed field and pulses reg_write with the result.
//   Misaligned requests, illegal funct3 and memory timeouts pulse err instead.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high
//   start      request strobe, sampled in IDLE only
//   addr       byte address of the load
//   funct3     load type (LB LH LW LD LBU LHU LWU, 111 illegal)
//   busy       high whenever the unit is not IDLE
//   mem_rd     memory read request, high throughout RD
//   mem_addr   doubleword-aligned read address
//   mem_rdata  memory read data, valid with mem_valid
//   mem_valid  memory response strobe, honoured only in RD
//   reg_write  one-cycle destination register write strobe
//   load_data  extended load result, holds until the next capture
//   err        one-cycle error pulse
//   err_code   01 misaligned, 10 illegal funct3, 11 timeout; holds until next err
// ---------------------------------------------------------------------------
module mem_load_unit #(
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] addr,
   input  logic [2:0]        funct3,
   output logic              busy,
   output logic              mem_rd,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              reg_write,
   output logic [DATA_W-1:0] load_data,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   logic [1:0]        state;
   logic [DATA_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic [7:0]        cnt;
   logic [7:0]        cnt_nxt;

   logic              illegal;
   logic              misaligned;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] ext;

   // Outputs decode straight from state so an asynchronous reset drops them
   // immediately without waiting for a clock edge.
   assign busy      = (state != IDLE);
   assign mem_rd    = (state == RD);
   assign reg_write = (state == DONE);
   assign err       = (state == ERR);
   assign mem_addr  = {addr_q[DATA_W-1:3], 3'b000};
   assign cnt_nxt   = cnt + 8'd1;

   // Request decode, evaluated on the live inputs in the start cycle.
   // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word, 11 double.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      illegal    = (funct3 == 3'b111);
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = |addr[1:0];
         2'b11:   misaligned = |addr[2:0];
         default: misaligned = 1'b0;
      endcase
   end

   // Field extraction from the returned doubleword using the latched offset.
   always_comb begin
      shifted = mem_rdata >> {addr_q[2:0], 3'b000};
      case (f3_q)
         3'b000:  ext = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
         3'b001:  ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         3'b010:  ext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
         3'b100:  ext = {{(DATA_W-8){1'b0}},         shifted[7:0]};
         3'b101:  ext = {{(DATA_W-16){1'b0}},        shifted[15:0]};
         3'b110:  ext = {{(DATA_W-32){1'b0}},        shifted[31:0]};
         default: ext = shifted;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: all registers here are control/result flops, not storage arrays,
      // so each one is reset to give the defined post-reset output values.
      if (reset) begin
         state     <= IDLE;
         addr_q    <= '0;
         f3_q      <= '0;
         cnt       <= '0;
         load_data <= '0;
         err_code  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q <= addr;
                  f3_q   <= funct3;
                  cnt    <= '0;
                  // Illegal funct3 outranks misalignment.
                  if (illegal) begin
                     err_code <= CODE_ILLEGAL;
                     state    <= ERR;
                  end else if (misaligned) begin
                     err_code <= CODE_MISALIGN;
                     state    <= ERR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               // A response in the expiry cycle still counts as success.
               if (mem_valid) begin
                  load_data <= ext;
                  state     <= DONE;
               end else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt >= TMO) begin
                     err_code <= CODE_TIMEOUT;
                     state    <= ERR;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;

   localparam int DW  = 64;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] addr;
   logic [2:0]    funct3;
   logic          busy;
   logic          mem_rd;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid;
   logic          reg_write;
   logic [DW-1:0] load_data;
   logic          err;
   logic [1:0]    err_code;

   typedef struct {
      bit            ok;
      logic [DW-1:0] data;
      logic [1:0]    code;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] last_data = '0;

   mem_load_unit #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .addr      (addr),
      .funct3    (funct3),
      .busy      (busy),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .reg_write (reg_write),
      .load_data (load_data),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running, need finished");
      $fatal(1, "global timeout");
   end

   // One request: push the expectation, raise start in cycle 0, answer the
   // read in RD cycle vcyc (negative = never), pop and compare on the strobe.
   task automatic run_load(input string name, input logic [DW-1:0] a,
                           input logic [2:0] f3, input logic [DW-1:0] rdata,
                           input int vcyc, input bit poke,
                           input bit ok, input logic [DW-1:0] ed,
                           input logic [1:0] ec, input int ecyc);
      exp_t e;
      int   c;
      int   rd_cnt;
      int   exp_rd;
      bit   done;
      sb.push_back('{ok, ed, ec, ecyc});
      exp_rd = (ecyc == 1) ? 0 : ecyc - 1;
      @(negedge clk);
      start = 1'b1; addr = a; funct3 = f3;
      c = 0; rd_cnt = 0; done = 1'b0;
      while (!done && c < 40) begin
         @(negedge clk);
         c++;
         start = 1'b0; addr = ~a; funct3 = 3'b111;
         mem_valid = 1'b0; mem_rdata = ~rdata;
         if (poke && c == 2) begin
            start = 1'b1; addr = '0; funct3 = 3'b011;
         end
         if (mem_rd) begin
            rd_cnt++;
            if (rd_cnt == 1) begin
               n_cmp++;
               if (mem_addr !== {a[DW-1:3], 3'b000}) begin
                  n_bad++;
                  $display("FAIL %s mem_addr: got %h need %h", name, mem_addr, {a[DW-1:3], 3'b000});
               end
            end
            if (c - 1 == vcyc) begin
               mem_valid = 1'b1; mem_rdata = rdata;
            end
         end
         if (reg_write || err) begin
            done = 1'b1;
            e = sb.pop_front();
            n_cmp++;
            if (reg_write !== e.ok || err !== !e.ok) begin
               n_bad++;
               $display("FAIL %s strobe: got wr=%b err=%b need wr=%b err=%b", name, reg_write, err, e.ok, !e.ok);
            end
            n_cmp++;
            if (c != e.cyc) begin
               n_bad++;
               $display("FAIL %s latency: got cycle %0d need cycle %0d", name, c, e.cyc);
            end
            n_cmp++;
            if (e.ok) begin
               if (load_data !== e.data) begin
                  n_bad++;
                  $display("FAIL %s load_data: got %h need %h", name, load_data, e.data);
               end
               last_data = e.data;
            end else begin
               if (err_code !== e.code || load_data !== last_data) begin
                  n_bad++;
                  $display("FAIL %s err_code/load_data: got %b/%h need %b/%h", name, err_code, load_data, e.code, last_data);
               end
            end
         end
      end
      start = 1'b0; mem_valid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s no_response: got none in 40 cycles, need strobe", name);
      end else if (rd_cnt != exp_rd) begin
         n_bad++;
         $display("FAIL %s mem_rd_cycles: got %0d need %0d", name, rd_cnt, exp_rd);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; addr = '0; funct3 = '0;
      mem_rdata = '0; mem_valid = 1'b0;
      #12;
      n_cmp++;
      if ({busy, mem_rd, mem_addr, reg_write, load_data, err, err_code} !== '0) begin
         n_bad++;
         $display("FAIL reset_values: got busy=%b rd=%b maddr=%h wr=%b data=%h err=%b code=%b need all zero",
                  busy, mem_rd, mem_addr, reg_write, load_data, err, err_code);
      end
      @(negedge clk);
      reset = 1'b0;
      last_data = '0;
   endtask

   task automatic test_extract;
      run_load("ld",  64'h1000, 3'b011, 64'h1122334455667788, 0, 0, 1, 64'h1122334455667788, 2'b00, 2);
      run_load("lb",  64'h1007, 3'b000, 64'h80FFFFFFFFFFFFFF, 0, 0, 1, 64'hFFFFFFFFFFFFFF80, 2'b00, 2);
      run_load("lbu", 64'h1007, 3'b100, 64'h80FFFFFFFFFFFFFF, 0, 0, 1, 64'h0000000000000080, 2'b00, 2);
      run_load("lw",  64'h1004, 3'b010, 64'h8765432100000000, 0, 0, 1, 64'hFFFFFFFF87654321, 2'b00, 2);
      run_load("lwu", 64'h1004, 3'b110, 64'h8765432100000000, 0, 0, 1, 64'h0000000087654321, 2'b00, 2);
      run_load("lh",  64'h1002, 3'b001, 64'h000000007FFF0000, 0, 0, 1, 64'h0000000000007FFF, 2'b00, 2);
      run_load("lh_neg", 64'h1006, 3'b001, 64'h8001000000000000, 2, 0, 1, 64'hFFFFFFFFFFFF8001, 2'b00, 4);
      run_load("lhu", 64'h1006, 3'b101, 64'h8001000000000000, 1, 0, 1, 64'h0000000000008001, 2'b00, 3);
      run_load("lb3", 64'h2003, 3'b000, 64'h000000007A000000, 0, 0, 1, 64'h000000000000007A, 2'b00, 2);
   endtask

   task automatic test_errors;
      run_load("mis_lh", 64'h1001, 3'b001, 64'h0, 0, 0, 0, 64'h0, 2'b01, 1);
      run_load("mis_lw", 64'h1002, 3'b010, 64'h0, 0, 0, 0, 64'h0, 2'b01, 1);
      run_load("mis_ld", 64'h1004, 3'b011, 64'h0, 0, 0, 0, 64'h0, 2'b01, 1);
      run_load("illegal", 64'h1001, 3'b111, 64'h0, 0, 0, 0, 64'h0, 2'b10, 1);
   endtask

   task automatic test_timeout;
      run_load("timeout", 64'h1008, 3'b011, 64'h0, -1, 1, 0, 64'h0, 2'b11, TMO + 1);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || reg_write !== 1'b0) begin
         n_bad++;
         $display("FAIL start_during_rd: got busy=%b wr=%b need 0/0", busy, reg_write);
      end
      // Response in the last allowed cycle beats the expiry.
      run_load("valid_at_expiry", 64'h1010, 3'b011, 64'hCAFEF00D12345678, TMO - 1, 0, 1,
               64'hCAFEF00D12345678, 2'b00, TMO + 1);
   endtask

   task automatic test_idle_valid;
      @(negedge clk);
      mem_valid = 1'b1; mem_rdata = 64'hDEAD;
      @(negedge clk);
      mem_valid = 1'b0;
      n_cmp++;
      if (reg_write !== 1'b0 || busy !== 1'b0 || load_data !== last_data) begin
         n_bad++;
         $display("FAIL idle_valid: got wr=%b busy=%b data=%h need 0/0/%h", reg_write, busy, load_data, last_data);
      end
   endtask

   task automatic test_back_to_back;
      run_load("b2b_0", 64'h3000, 3'b011, 64'h0102030405060708, 0, 0, 1, 64'h0102030405060708, 2'b00, 2);
      run_load("b2b_1", 64'h3001, 3'b100, 64'h0102030405060708, 0, 0, 1, 64'h0000000000000007, 2'b00, 2);
      run_load("b2b_2", 64'h3004, 3'b110, 64'hF00000000102030F, 0, 0, 1, 64'h00000000F0000000, 2'b00, 2);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; addr = 64'h4000; funct3 = 3'b011;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (mem_rd !== 1'b0 || busy !== 1'b0 || load_data !== '0 || err_code !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_mid_async: got rd=%b busy=%b data=%h code=%b need 0/0/0/00", mem_rd, busy, load_data, err_code);
      end
      mem_valid = 1'b1; mem_rdata = 64'h55;
      @(negedge clk);
      n_cmp++;
      if (reg_write !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_strobe: got wr=%b err=%b need 0/0", reg_write, err);
      end
      reset = 1'b0; mem_valid = 1'b0;
      last_data = '0;
      run_load("after_reset", 64'h4008, 3'b011, 64'h0BADBEEF0BADBEEF, 0, 0, 1, 64'h0BADBEEF0BADBEEF, 2'b00, 2);
   endtask

   initial begin
      test_reset();
      test_extract();
      test_errors();
      test_timeout();
      test_idle_valid();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left need 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Multi-cycle load controller that sits between the datapath and data memory, on the writing side of the 64-bit data register. It accepts a RISC-V load request (address + funct3), issues a doubleword-aligned read to memory, waits for the memory's valid response, then extracts, sign- or zero-extends the addressed field and pulses a single-cycle write strobe with the 64-bit result. Misaligned or illegal requests and memory timeouts are flagged instead of written.

## Interface
- DATA_W, 64, data and address width
- TIMEOUT, 15, max cycles in RD waiting for mem_valid before abort (range 1..255)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request strobe, sampled in IDLE only
- addr  in  DATA_W  byte address of load
- funct3  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal
- busy  out  1  high in any state other than IDLE
- mem_rd  out  1  read request to memory, high throughout RD
- mem_addr  out  DATA_W  {addr_q[DATA_W-1:3], 3'b000}; valid while mem_rd
- mem_rdata  in  DATA_W  memory read data, valid when mem_valid
- mem_valid  in  1  memory response strobe, honoured only in RD
- reg_write  out  1  one-cycle write strobe for the destination register
- load_data  out  DATA_W  extended load result; holds until next capture
- err  out  1  one-cycle error pulse
- err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout; holds until next err

## Operation
- States: IDLE, RD, DONE, ERR. Reset state IDLE.
- IDLE: on start=1, latch addr→addr_q, funct3→f3_q. Illegal funct3 → ERR (code 10). Else misaligned (half: addr[0]≠0; word: addr[1:0]≠0; double: addr[2:0]≠0) → ERR (code 01); illegal takes priority over misaligned. Else → RD, clear timeout counter.
- RD: mem_rd=1. mem_valid=1 → capture extended data into load_data, → DONE. Otherwise increment counter; counter reaching TIMEOUT with no mem_valid → ERR (code 11), mem_rd drops.
- DONE: reg_write=1 for exactly this cycle, → IDLE.
- ERR: err=1 for exactly this cycle, err_code updated on entry, → IDLE. load_data unchanged, reg_write stays 0.
- Extraction: off = addr_q[2:0]; s = mem_rdata >> (8*off). LB/LBU: s[7:0] sign/zero-extended; LH/LHU: s[15:0]; LW/LWU: s[31:0]; LD: s[63:0].
- start while busy is ignored (no queueing). mem_valid outside RD is ignored.
- Inputs addr/funct3 may change after the start cycle; only latched copies are used.

## Timing
- Reset values: busy 0, mem_rd 0, mem_addr 0, reg_write 0, load_data 0, err 0, err_code 00; asserting reset mid-operation forces these immediately and returns to IDLE without a strobe.
- Edge 0 samples start; RD from cycle 1. mem_valid seen in cycle 1 → reg_write high in cycle 2 (minimum latency 2 cycles start→strobe); each extra wait cycle adds one.
- load_data updates on the same edge that enters DONE, so it is valid while reg_write=1.
- Error path: err high the cycle after start (decode errors) or the cycle after the TIMEOUT-th waiting cycle (timeout).
- Throughput: new start accepted in the cycle after DONE/ERR (IDLE); back-to-back best case one load per 3 cycles.
- mem_valid and counter expiry in the same cycle: mem_valid wins (success).

## Test plan
- LD addr=0x1000, mem_valid in cycle 1 with rdata=0x1122334455667788 → mem_addr=0x1000, reg_write in cycle 2, load_data=0x1122334455667788.
- LB addr=0x1007, rdata=0x80FF_FFFF_FFFF_FFFF → mem_addr=0x1000, load_data=0xFFFFFFFFFFFFFF80; same with LBU → 0x0000000000000080.
- LW addr=0x1004, rdata=0x8765432100000000 → 0xFFFFFFFF87654321; LWU → 0x0000000087654321; LH addr=0x1002, rdata=0x0000_0000_7FFF_0000 → 0x0000000000007FFF.
- LH addr=0x1001 → no mem_rd, err pulse cycle 1, err_code 01; funct3=111 addr=0x1001 → err_code 10; load_data unchanged.
- LD with mem_valid never asserted, TIMEOUT=4 → mem_rd high 4 cycles, err with code 11, no reg_write; start asserted during RD ignored.
- Reset asserted in RD → mem_rd/busy drop asynchronously, no reg_write; next LD after reset completes normally.
